ilm_accumulator: RTL and testbench
==================================

# ilm_accumulator

Sequential dot-product accumulator placed directly downstream of the ILM log multiplier. It accepts one 17-bit sign-magnitude product per handshake, converts it to two's complement, and accumulates it into a saturating signed register. When the beat marked last arrives, it presents the total, beat count and overflow flag on an output handshake. It turns the combinational ILM into a streaming MAC for filter and matrix-vector work.

## Interface
Parameters:
- ACC_W, 24: accumulator width, two's complement. Legal range is 18 to 32.
- CNT_W, 8: beat counter width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- clear, input, 1: synchronous abort; discards the vector in progress.
- in_valid, input, 1: product beat valid.
- in_ready, output, 1: block can accept a beat.
- in_prod, input, 17: ILM product. Bit 16 is the sign (1 = negative); bits 15:0 are the magnitude.
- in_last, input, 1: this beat ends the vector; qualified by in_valid.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_acc, output, ACC_W: signed accumulated total.
- out_cnt, output, CNT_W: number of beats in the vector.
- out_ovf, output, 1: saturation occurred or the counter saturated during the vector.

## Operation
- States:
  - ACC: collecting beats.
  - DONE: holding the result.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, out_acc=0, out_cnt=0, out_ovf=0.
- in_ready = (state==ACC) and not clear.
- Input conversion:
  - value = sign ? -{0,mag} : {0,mag}, sign-extended to ACC_W.
  - Negative zero (sign=1, mag=0) converts to 0.
- Accumulate on beat acceptance (in_valid and in_ready):
  - sum = acc + value, computed in ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1: acc is clamped to the maximum and ovf is set.
  - If sum < -2^(ACC_W-1): acc is clamped to the minimum and ovf is set.
  - Otherwise acc = sum.
  - ovf is sticky for the rest of the vector.
- Beat counting:
  - cnt increments on every accepted beat.
  - At 2^CNT_W-1, cnt holds its value and ovf is set.
- Transitions:
  - ACC to DONE: on an accepted beat with in_last=1. The final beat is included in acc and cnt. out_valid rises the next cycle.
  - DONE to ACC: when out_valid and out_ready. acc, cnt and ovf clear to 0 on that edge.
- In DONE, out_acc, out_cnt and out_ovf are stable and equal to the internal registers. in_ready=0, so no beat is accepted in that state.
- In ACC, out_acc, out_cnt and out_ovf are don't-care; the bench checks them only while out_valid=1.
- clear:
  - In any state, clear forces state=ACC, acc=0, cnt=0, ovf=0 and out_valid=0 on the next edge.
  - A beat presented while clear=1 is not accepted (in_ready=0).
  - clear has priority over everything except rst.
- rst asserted mid-vector or in DONE: all registers return to their reset values immediately, and the partial result is lost.

## Timing
- Accumulate latency: 1 cycle. The beat accepted at edge n is reflected in acc after edge n.
- Result latency: out_valid=1 from the cycle after the last beat's edge.
- Throughput:
  - Within a vector, 1 beat per cycle.
  - Between vectors, at least 1 bubble cycle (the DONE cycle), plus any out_ready stall.
- out_valid and the result fields hold while out_ready=0. They never drop without a handshake unless clear or rst occurs.
- The critical path (negate, add, saturate mux) must close in one cycle. No combinational path runs from in_valid or out_ready to in_ready; in_ready depends only on state and clear.

## Structure
- Package ilm_pkg:
  - PROD_W=17, MAG_W=16, SIGN_BIT=16.
  - State enum acc_state_t {ACC, DONE}.
  - Saturation helper constants derived from ACC_W.
- Sub-module sm_to_tc: purely combinational sign-magnitude to two's-complement converter, parameterised by output width. It is reused by other consumers of ILM output.
- The top level holds the FSM, saturating adder, counter and output registers.

## Test plan
- Basic vector: beats +100 (17'h00064), -30 (17'h1001E), +5 with in_last. Required: out_valid the cycle after the last beat, out_acc=75, out_cnt=3, out_ovf=0. One handshake returns the block to ACC with acc=0.
- Saturation, ACC_W=18:
  - Four beats of +65535 (17'h0FFFF), last on the 4th. Required: out_acc=131071, out_ovf=1, out_cnt=4.
  - Mirror with 17'h1FFFF beats. Required: out_acc=-131072, out_ovf=1.
- Negative zero and single beat: one beat 17'h10000 with in_last. Required: out_acc=0, out_cnt=1, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after the result. Required: out_valid and fields stay stable and in_ready=0. A beat offered during the stall is not consumed; after the handshake it is accepted as the first beat of the next vector.
- Abort:
  - Assert clear after 2 beats (+7, +9), then send +3 with in_last. Required: out_acc=3, out_cnt=1.
  - Repeat with rst pulsed asynchronously mid-vector. Required: all outputs read their reset values before the next rising edge.
- Counter saturation, CNT_W=2: 5 beats of +1. Required: out_cnt=3, out_ovf=1, out_acc=5.

Source files
------------

// File: rtl/ilm_accumulator_pkg.sv
// Shared constants, state type and saturation helpers for the ILM accumulator.
package ilm_pkg;

  localparam int PROD_W   = 17;
  localparam int MAG_W    = 16;
  localparam int SIGN_BIT = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  // Largest positive value of a w-bit two's-complement accumulator (w <= 32).
  function automatic logic signed [32:0] acc_max(input int w);
    logic signed [32:0] one;
    one = 33'sd1;
    return (one <<< (w - 1)) - 33'sd1;
  endfunction

  // Most negative value of a w-bit two's-complement accumulator (w <= 32).
  function automatic logic signed [32:0] acc_min(input int w);
    logic signed [32:0] one;
    one = 33'sd1;
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/ilm_accumulator_if.sv
// Product-in / result-out handshake bundle of the ILM accumulator.
interface ilm_accumulator_if
  import ilm_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

endinterface

// File: rtl/ilm_accumulator_sm_to_tc.sv
// Sign-magnitude ILM product to sign-extended two's-complement converter.
module sm_to_tc
  import ilm_pkg::*;
#(
  parameter int OUT_W = 24
) (
  input  logic [PROD_W-1:0]       sm_i,
  output logic signed [OUT_W-1:0] tc_o
);

  logic [OUT_W-1:0] mag_ext;

  // Zero-extend the magnitude and negate when the sign is set; -0 naturally yields 0.
  always_comb begin
    mag_ext = {{(OUT_W - MAG_W){1'b0}}, sm_i[MAG_W-1:0]};
    tc_o    = sm_i[SIGN_BIT] ? -mag_ext : mag_ext;
  end

endmodule

// File: rtl/ilm_accumulator.sv
// Streaming saturating dot-product accumulator fed by the ILM log multiplier.
module ilm_accumulator
  import ilm_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  input logic               clear,
  ilm_accumulator_if.slave  bus
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  acc_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] beat_val;
  logic signed [ACC_W:0]   sum;
  logic                    sum_pos_ovf;
  logic                    sum_neg_ovf;
  logic                    cnt_full;
  logic                    accept;

  sm_to_tc #(.OUT_W(ACC_W)) u_conv (
    .sm_i (bus.in_prod),
    .tc_o (beat_val)
  );

  assign bus.in_ready  = (state_q == ACC) && !clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_acc   = acc_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;

  // One extra bit of headroom; the top two bits disagreeing means the sum left the ACC_W range.
  assign sum         = {acc_q[ACC_W-1], acc_q} + {beat_val[ACC_W-1], beat_val};
  assign sum_pos_ovf = !sum[ACC_W] && sum[ACC_W-1];
  assign sum_neg_ovf = sum[ACC_W] && !sum[ACC_W-1];
  assign cnt_full    = &cnt_q;

  // Next-state logic: clear wins, otherwise accumulate in ACC or wait for the result handshake in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (sum_pos_ovf) begin
              acc_d = ACC_MAX;
            end else if (sum_neg_ovf) begin
              acc_d = ACC_MIN;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
            cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q || sum_pos_ovf || sum_neg_ovf || cnt_full;
            if (bus.in_last) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State and datapath registers; reset drops any partial vector immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ilm_accumulator.sv
// Directed self-checking bench for ilm_accumulator (ACC_W=18; a second copy with CNT_W=2).
module tb_ilm_accumulator;
  import ilm_pkg::*;

  logic clk;
  logic rst;
  logic clear;
  int   checks;
  int   errors;

  ilm_accumulator_if #(.ACC_W(18), .CNT_W(8)) a_if ();
  ilm_accumulator_if #(.ACC_W(18), .CNT_W(2)) b_if ();

  ilm_accumulator #(.ACC_W(18), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (a_if.slave)
  );

  ilm_accumulator #(.ACC_W(18), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (b_if.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one beat to DUT A for exactly one clock edge.
  task automatic send_a(input logic [16:0] prod, input logic last);
    a_if.in_valid = 1'b1;
    a_if.in_prod  = prod;
    a_if.in_last  = last;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  // Present one beat to DUT B for exactly one clock edge.
  task automatic send_b(input logic [16:0] prod, input logic last);
    b_if.in_valid = 1'b1;
    b_if.in_prod  = prod;
    b_if.in_last  = last;
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
  endtask

  // Accept the pending result of DUT A with a one-cycle out_ready pulse.
  task automatic take_a();
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_if.in_ready); end
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'h0) begin errors++; $display("[TB] FAIL reset_out_acc: got %h expected 0", a_if.out_acc); end
    checks++; if (a_if.out_cnt !== 8'h0) begin errors++; $display("[TB] FAIL reset_out_cnt: got %h expected 0", a_if.out_cnt); end
    checks++; if (a_if.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf: got %b expected 0", a_if.out_ovf); end
    checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_out_valid: got %b expected 0", b_if.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_a(17'h00064, 1'b0);
    send_a(17'h1001E, 1'b0);
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", a_if.out_valid); end
    send_a(17'h00005, 1'b1);
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid: got %b expected 1", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'd75) begin errors++; $display("[TB] FAIL basic_out_acc: got %0d expected 75", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd3) begin errors++; $display("[TB] FAIL basic_out_cnt: got %0d expected 3", a_if.out_cnt); end
    checks++; if (a_if.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_out_ovf: got %b expected 0", a_if.out_ovf); end
    checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_in_ready: got %b expected 0", a_if.in_ready); end
    take_a();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_hs_valid: got %b expected 0", a_if.out_valid); end
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_after_hs_ready: got %b expected 1", a_if.in_ready); end
    checks++; if (dut_a.acc_q !== 18'h0) begin errors++; $display("[TB] FAIL basic_acc_cleared: got %h expected 0", dut_a.acc_q); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send_a(17'h0FFFF, (i == 3));
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL satpos_out_valid: got %b expected 1", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'h1FFFF) begin errors++; $display("[TB] FAIL satpos_out_acc: got %0d expected 131071", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd4) begin errors++; $display("[TB] FAIL satpos_out_cnt: got %0d expected 4", a_if.out_cnt); end
    checks++; if (a_if.out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL satpos_out_ovf: got %b expected 1", a_if.out_ovf); end
    take_a();
    for (int i = 0; i < 4; i++) send_a(17'h1FFFF, (i == 3));
    checks++; if (a_if.out_acc !== 18'h20000) begin errors++; $display("[TB] FAIL satneg_out_acc: got %0d expected -131072", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL satneg_out_ovf: got %b expected 1", a_if.out_ovf); end
    take_a();
  endtask

  task automatic test_neg_zero();
    send_a(17'h10000, 1'b1);
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL negzero_out_valid: got %b expected 1", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'h0) begin errors++; $display("[TB] FAIL negzero_out_acc: got %0d expected 0", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd1) begin errors++; $display("[TB] FAIL negzero_out_cnt: got %0d expected 1", a_if.out_cnt); end
    checks++; if (a_if.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL negzero_out_ovf: got %b expected 0", a_if.out_ovf); end
    take_a();
  endtask

  task automatic test_backpressure();
    send_a(17'h00002, 1'b1);
    a_if.in_valid = 1'b1;
    a_if.in_prod  = 17'h00009;
    a_if.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid[%0d]: got %b expected 1", i, a_if.out_valid); end
      checks++; if (a_if.out_acc !== 18'd2) begin errors++; $display("[TB] FAIL stall_out_acc[%0d]: got %0d expected 2", i, $signed(a_if.out_acc)); end
      checks++; if (a_if.out_cnt !== 8'd1) begin errors++; $display("[TB] FAIL stall_out_cnt[%0d]: got %0d expected 1", i, a_if.out_cnt); end
      checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, a_if.in_ready); end
      @(posedge clk); #1;
    end
    take_a();
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hs_valid: got %b expected 0", a_if.out_valid); end
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_valid: got %b expected 1", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'd9) begin errors++; $display("[TB] FAIL stall_next_acc: got %0d expected 9", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd1) begin errors++; $display("[TB] FAIL stall_next_cnt: got %0d expected 1", a_if.out_cnt); end
    take_a();
  endtask

  task automatic test_abort();
    send_a(17'h00007, 1'b0);
    send_a(17'h00009, 1'b0);
    clear         = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_prod  = 17'h00064;
    a_if.in_last  = 1'b1;
    #1;
    checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_in_ready: got %b expected 0", a_if.in_ready); end
    @(posedge clk); #1;
    clear         = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_out_valid: got %b expected 0", a_if.out_valid); end
    send_a(17'h00003, 1'b1);
    checks++; if (a_if.out_acc !== 18'd3) begin errors++; $display("[TB] FAIL clear_out_acc: got %0d expected 3", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clear_out_cnt: got %0d expected 1", a_if.out_cnt); end
    take_a();

    send_a(17'h00007, 1'b0);
    send_a(17'h00009, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", a_if.in_ready); end
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", a_if.out_valid); end
    checks++; if (a_if.out_acc !== 18'h0) begin errors++; $display("[TB] FAIL rst_out_acc: got %0d expected 0", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_out_cnt: got %0d expected 0", a_if.out_cnt); end
    checks++; if (a_if.out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_ovf: got %b expected 0", a_if.out_ovf); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_a(17'h00003, 1'b1);
    checks++; if (a_if.out_acc !== 18'd3) begin errors++; $display("[TB] FAIL rst_next_acc: got %0d expected 3", $signed(a_if.out_acc)); end
    checks++; if (a_if.out_cnt !== 8'd1) begin errors++; $display("[TB] FAIL rst_next_cnt: got %0d expected 1", a_if.out_cnt); end
    take_a();
  endtask

  task automatic test_counter_sat();
    for (int i = 0; i < 3; i++) send_b(17'h00001, 1'b0);
    checks++; if (dut_b.ovf_q !== 1'b0) begin errors++; $display("[TB] FAIL cntsat_ovf_at_3: got %b expected 0", dut_b.ovf_q); end
    send_b(17'h00001, 1'b0);
    checks++; if (dut_b.ovf_q !== 1'b1) begin errors++; $display("[TB] FAIL cntsat_ovf_at_4: got %b expected 1", dut_b.ovf_q); end
    send_b(17'h00001, 1'b1);
    checks++; if (b_if.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL cntsat_out_valid: got %b expected 1", b_if.out_valid); end
    checks++; if (b_if.out_cnt !== 2'd3) begin errors++; $display("[TB] FAIL cntsat_out_cnt: got %0d expected 3", b_if.out_cnt); end
    checks++; if (b_if.out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL cntsat_out_ovf: got %b expected 1", b_if.out_ovf); end
    checks++; if (b_if.out_acc !== 18'd5) begin errors++; $display("[TB] FAIL cntsat_out_acc: got %0d expected 5", $signed(b_if.out_acc)); end
    b_if.out_ready = 1'b1;
    @(posedge clk); #1;
    b_if.out_ready = 1'b0;
    checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL cntsat_hs_valid: got %b expected 0", b_if.out_valid); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks         = 0;
    errors         = 0;
    clear          = 1'b0;
    a_if.in_valid  = 1'b0;
    a_if.in_prod   = '0;
    a_if.in_last   = 1'b0;
    a_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b0;
    b_if.in_prod   = '0;
    b_if.in_last   = 1'b0;
    b_if.out_ready = 1'b0;
    test_reset();
    $display("[TB] basic vector");
    test_basic();
    $display("[TB] saturation");
    test_saturation();
    $display("[TB] negative zero");
    test_neg_zero();
    $display("[TB] backpressure");
    test_backpressure();
    $display("[TB] abort");
    test_abort();
    $display("[TB] counter saturation");
    test_counter_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
